// File: rtl/host_wr_queue.sv
// -----------------------------------------------------------------------------
// host_wr_queue
//
// Host bus front end for the OPL3 core. CPU-style writes to an address port
// and a data port are decoded across a set of register banks. Completed
// register writes (bank, register address, register data) are queued in a
// FIFO and drained to the register file with a minimum spacing, so a host
// can burst faster than the core accepts writes. Status readback carries a
// queue-busy flag in bit 0.
//
// Ports:
//   clk            opl3 clock (single clock domain)
//   reset          synchronous, active-high
//   cs_n           chip select, active low (already synchronous to clk)
//   rd_n           read strobe, active low
//   wr_n           write strobe, active low
//   address        host address; [0] = port (0 addr, 1 data), upper = bank
//   din            host write data
//   dout           registered status readback, bit 0 = queue not empty
//   status         core status (bit 0 not driven meaningfully by the core)
//   reg_wr_valid   one-cycle register write pulse
//   reg_wr_bank    bank of the register write
//   reg_wr_address register address of the write
//   reg_wr_data    register data of the write
//   level          current FIFO occupancy
//   overflow       sticky: a data write was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module host_wr_queue #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int MIN_GAP    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cs_n,
  input  logic                          rd_n,
  input  logic                          wr_n,
  input  logic [ADDR_WIDTH-1:0]         address,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic [DATA_WIDTH-1:0]         dout,
  input  logic [DATA_WIDTH-1:0]         status,
  output logic                          reg_wr_valid,
  output logic [ADDR_WIDTH-2:0]         reg_wr_bank,
  output logic [DATA_WIDTH-1:0]         reg_wr_address,
  output logic [DATA_WIDTH-1:0]         reg_wr_data,
  output logic [$clog2(DEPTH+1)-1:0]    level,
  output logic                          overflow
);

  localparam int BANK_W = ADDR_WIDTH - 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int GAP_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  typedef struct packed {
    logic [BANK_W-1:0]     bank;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Input stage. Strobes are stored active-high so that the cleared (reset)
  // state of the pipeline means "no strobe"; a strobe held across reset
  // release then produces exactly one write event.
  // ---------------------------------------------------------------------------
  logic                  cs_p1;
  logic                  rd_p1;
  logic                  wr_p1;
  logic [ADDR_WIDTH-1:0] address_p1;
  logic [DATA_WIDTH-1:0] din_p1;
  logic                  wr_p2;

  // Write strobe as seen one stage later; the event fires on the first p1
  // cycle of each strobe, however long the host holds it.
  logic wr_sel_p1;
  logic wr_event;
  logic addr_event;
  logic data_event;

  // Latched register address and bank from the last address-port write.
  logic [DATA_WIDTH-1:0] addr_latch;
  logic [BANK_W-1:0]     bank_latch;

  // FIFO storage and bookkeeping.
  entry_t               mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [GAP_W-1:0]     gcnt;

  logic   push;
  logic   pop;
  logic   drop;
  entry_t push_entry;

  // Bit 0 of the core status is replaced by the busy flag.
  logic unused_status_bit;
  assign unused_status_bit = status[0];

  // ---------------------------------------------------------------------------
  // Event decode and FIFO control.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wr_sel_p1  = 1'b0;
    wr_event   = 1'b0;
    addr_event = 1'b0;
    data_event = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    drop       = 1'b0;
    push_entry = '0;

    wr_sel_p1 = cs_p1 & wr_p1;
    // Read and write asserted together is a bus conflict: no event at all.
    wr_event  = wr_sel_p1 & ~rd_p1 & ~wr_p2;

    addr_event = wr_event & ~address_p1[0];
    data_event = wr_event &  address_p1[0];

    pop = (level != '0) && (gcnt == '0);

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    if (data_event) begin
      if ((level < LVL_W'(DEPTH)) || pop) begin
        push = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    // Bank bits on a data-port write are ignored; the latched bank is used.
    push_entry.bank = bank_latch;
    push_entry.addr = addr_latch;
    push_entry.data = din_p1;
  end

  // ---------------------------------------------------------------------------
  // Input pipeline, address latch, pointers, drain pacing and outputs.
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_p1          <= 1'b0;
      rd_p1          <= 1'b0;
      wr_p1          <= 1'b0;
      address_p1     <= '0;
      din_p1         <= '0;
      wr_p2          <= 1'b0;
      addr_latch     <= '0;
      bank_latch     <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      gcnt           <= '0;
      overflow       <= 1'b0;
      reg_wr_valid   <= 1'b0;
      reg_wr_bank    <= '0;
      reg_wr_address <= '0;
      reg_wr_data    <= '0;
      dout           <= '0;
    end else begin
      cs_p1      <= ~cs_n;
      rd_p1      <= ~rd_n;
      wr_p1      <= ~wr_n;
      address_p1 <= address;
      din_p1     <= din;
      wr_p2      <= wr_sel_p1;

      if (addr_event) begin
        addr_latch <= din_p1;
        bank_latch <= address_p1[ADDR_WIDTH-1:1];
      end

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      if (drop) begin
        overflow <= 1'b1;
      end

      // Pop: present the head for one cycle and restart the spacing timer.
      // The bank/address/data outputs hold their values between pulses.
      reg_wr_valid <= pop;
      if (pop) begin
        rd_ptr         <= rd_ptr + PTR_W'(1);
        reg_wr_bank    <= mem[rd_ptr].bank;
        reg_wr_address <= mem[rd_ptr].addr;
        reg_wr_data    <= mem[rd_ptr].data;
        gcnt           <= GAP_W'(MIN_GAP);
      end else if (gcnt != '0) begin
        gcnt <= gcnt - GAP_W'(1);
      end

      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      dout <= {status[DATA_WIDTH-1:1], (level != '0)};
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and level define which
  // slots are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

endmodule
